// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time,
// latches the returned word and presents decoded fields to decode/control.
//
// Handshake rules (all ports):
//   imem:  imem_req is held high in FETCH until imem_gnt is seen on a rising
//          edge. Exactly one request is outstanding; imem_rvalid is only
//          honoured while waiting for that response.
//   out:   an instruction transfers on a rising edge where out_valid and
//          out_ready are both high. While out_valid is high and out_ready is
//          low, every field and pc_out stay stable. out_valid drops only on a
//          completed transfer, a redirect, or reset.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  instr_op,
  output logic [5:0]  instr_field,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Reset PC with the low bits forced so the fetch address is always aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic        load_en;
  logic        count_en;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] count_q;
  logic [31:0] redirect_pc;
  logic [31:0] pc_inc;

  assign redirect_pc = {redirect_target[31:2], 2'b00};
  assign pc_inc      = pc_q + 32'd4;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; a redirect outranks every other event
  // except in RESET, where it is ignored.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    load_en   = 1'b0;
    count_en  = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // A grant in the same cycle was for the old PC; its data is stale.
          if (imem_gnt) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d   = S_WAIT;
          discard_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            load_en = 1'b1;
            pc_d    = pc_inc;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          // A transfer completing in the same cycle still counts.
          valid_d  = 1'b0;
          pc_d     = redirect_pc;
          count_en = out_ready;
          state_d  = S_FETCH;
        end else if (out_ready) begin
          valid_d  = 1'b0;
          count_en = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Datapath registers: PC, discard flag, presented instruction and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC_ALIGNED;
      discard_q  <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      pc_out_q   <= 32'd0;
      pc_plus4_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      if (load_en) begin
        instr_q    <= imem_rdata;
        pc_out_q   <= pc_q;
        pc_plus4_q <= pc_inc;
      end
      if (count_en) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Request is a Moore output of FETCH; the address always shows the PC.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign out_valid   = valid_q;
  assign instr_op    = instr_q[31:26];
  assign instr_field = instr_q[5:0];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign imm_sext    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_plus4_q;
  assign instr_count = count_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized memory,
// redirect and consumer behaviour, checked every cycle against a
// transaction-level model (outstanding request / held instruction).
module tb_instr_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        out_ready = 1'b0;

  logic        a_imem_req, b_imem_req;
  logic [31:0] a_imem_addr, b_imem_addr;
  logic        a_out_valid, b_out_valid;
  logic [5:0]  a_instr_op, b_instr_op, a_instr_field, b_instr_field;
  logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
  logic [31:0] a_imm_sext, b_imm_sext, a_pc_out, b_pc_out;
  logic [31:0] a_pc_plus4, b_pc_plus4, a_instr_count, b_instr_count;
  logic [1:0]  a_fsm_state, b_fsm_state;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req(a_imem_req), .imem_addr(a_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .instr_op(a_instr_op), .instr_field(a_instr_field),
    .rs(a_rs), .rt(a_rt), .rd(a_rd), .imm_sext(a_imm_sext),
    .pc_out(a_pc_out), .pc_plus4(a_pc_plus4), .instr_count(a_instr_count),
    .fsm_state(a_fsm_state)
  );

  // Second instance exercises the PC wrap from the top of the address space.
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .instr_op(b_instr_op), .instr_field(b_instr_field),
    .rs(b_rs), .rt(b_rt), .rd(b_rd), .imm_sext(b_imm_sext),
    .pc_out(b_pc_out), .pc_plus4(b_pc_plus4), .instr_count(b_instr_count),
    .fsm_state(b_fsm_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (dut_a) ----------------
  logic        m_started = 1'b0;
  logic        m_outst   = 1'b0;
  logic        m_stale   = 1'b0;
  logic        m_held    = 1'b0;
  logic [31:0] m_pc      = 32'd0;
  logic [31:0] m_word    = 32'd0;
  logic [31:0] m_pc_out  = 32'd0;
  logic [31:0] m_pc4     = 32'd0;
  logic [31:0] m_count   = 32'd0;
  logic [31:0] m_tgt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 1'b0; m_outst = 1'b0; m_stale = 1'b0; m_held = 1'b0;
      m_pc = 32'd0; m_word = 32'd0; m_pc_out = 32'd0; m_pc4 = 32'd0;
      m_count = 32'd0;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else begin
      m_tgt = redirect_target & 32'hFFFF_FFFC;
      if (m_held) begin
        if (out_ready) m_count = m_count + 32'd1;
        if (out_ready || redirect_valid) m_held = 1'b0;
        if (redirect_valid) m_pc = m_tgt;
      end else if (m_outst) begin
        if (redirect_valid) begin
          m_pc = m_tgt;
          if (imem_rvalid) m_outst = 1'b0;
          else m_stale = 1'b1;
        end else if (imem_rvalid) begin
          m_outst = 1'b0;
          if (!m_stale) begin
            m_held   = 1'b1;
            m_word   = imem_rdata;
            m_pc_out = m_pc;
            m_pc4    = m_pc + 32'd4;
            m_pc     = m_pc + 32'd4;
          end
        end
      end else begin
        if (redirect_valid) m_pc = m_tgt;
        if (imem_gnt) begin
          m_outst = 1'b1;
          m_stale = redirect_valid;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("imem_req", a_imem_req, rst_n && m_started && !m_outst && !m_held);
    check("imem_addr", a_imem_addr, m_pc);
    check("out_valid", a_out_valid, m_held);
    check("instr_op", a_instr_op, m_word[31:26]);
    check("instr_field", a_instr_field, m_word[5:0]);
    check("rs", a_rs, m_word[25:21]);
    check("rt", a_rt, m_word[20:16]);
    check("rd", a_rd, m_word[15:11]);
    check("imm_sext", a_imm_sext, {{16{m_word[15]}}, m_word[15:0]});
    check("pc_out", a_pc_out, m_pc_out);
    check("pc_plus4", a_pc_plus4, m_pc4);
    check("instr_count", a_instr_count, m_count);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_target = 32'd0; out_ready = 1'b0;
  endtask

  task automatic random_cycles(input int n);
    int lat;
    lat = $urandom_range(0, 3);
    for (int c = 0; c < n; c++) begin
      imem_gnt   = ($urandom_range(0, 3) != 0);
      imem_rdata = $urandom;
      if (m_outst) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          lat = $urandom_range(0, 3);
        end else begin
          imem_rvalid = 1'b0;
          lat--;
        end
      end else begin
        imem_rvalid = ($urandom_range(0, 7) == 0);
      end
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      out_ready       = $urandom_range(0, 1);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst a addr", a_imem_addr, 32'h0);
    check("rst b addr", b_imem_addr, 32'hFFFF_FFFC);
    check("rst valid", a_out_valid, 0);
    check("rst count", a_instr_count, 0);
    rst_n = 1'b1;

    // add at address 0, immediate grant, one-cycle response, ready high
    @(negedge clk);
    check("first req", a_imem_req, 1);
    check("first addr", a_imem_addr, 32'h0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("add valid", a_out_valid, 1);
    check("add op", a_instr_op, 6'b000000);
    check("add func", a_instr_field, 6'b100000);
    check("add pc", a_pc_out, 32'h0);
    check("add pc4", a_pc_plus4, 32'h4);
    check("wrap pc", b_pc_out, 32'hFFFF_FFFC);
    check("wrap pc4", b_pc_plus4, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("add count", a_instr_count, 1);
    check("next addr", a_imem_addr, 32'h4);
    check("wrap next addr", b_imem_addr, 32'h0);

    // lw, then consumer stalls 5 cycles with junk gnt/rvalid around
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C22_FFFC;
    @(negedge clk);
    check("lw op", a_instr_op, 6'b100011);
    check("lw rs", a_rs, 5'd1);
    check("lw rt", a_rt, 5'd2);
    check("lw imm", a_imm_sext, 32'hFFFF_FFFC);
    check("lw pc", a_pc_out, 32'h4);
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall valid", a_out_valid, 1);
      check("stall req", a_imem_req, 0);
      check("stall count", a_instr_count, 1);
      check("stall op", a_instr_op, 6'b100011);
      check("stall imm", a_imm_sext, 32'hFFFF_FFFC);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("lw count", a_instr_count, 2);
    check("lw next addr", a_imem_addr, 32'h8);

    // redirect during WAIT drops the returning data
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("drop valid", a_out_valid, 0);
    check("drop req", a_imem_req, 1);
    check("drop addr", a_imem_addr, 32'h0000_0100);

    // redirect in HOLD together with ready still counts
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAC41_0008;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("sw pc", a_pc_out, 32'h0000_0100);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0040; out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b0;
    check("redir count", a_instr_count, 3);
    check("redir valid", a_out_valid, 0);
    check("redir addr", a_imem_addr, 32'h0000_0040);

    // randomized traffic
    random_cycles(4000);

    // wrap fetch on dut_b, then async reset in the following WAIT
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("wrap2 pc4", b_pc_plus4, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("wrap2 addr", b_imem_addr, 32'h0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async b valid", b_out_valid, 0);
    check("async b req", b_imem_req, 0);
    check("async b addr", b_imem_addr, 32'hFFFF_FFFC);
    check("async b pc", b_pc_out, 32'h0);
    check("async b pc4", b_pc_plus4, 32'h0);
    check("async b count", b_instr_count, 0);
    check("async b field", b_instr_field, 0);
    check("async a count", a_instr_count, 0);
    check("async a addr", a_imem_addr, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    rst_n = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("stale rvalid", a_out_valid, 0);
    check("post rst req", a_imem_req, 1);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of `controlUnit` and `aluControlUnit`. It owns the program counter and issues one word read at a time to instruction memory. It latches the returned word, splits it into the fields the decode/control logic consumes (`instr_op`, `instr_field`, register specifiers, sign-extended immediate), and presents them with a valid/ready handshake. Branch/jump redirects from downstream flush any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; low two bits must be 0.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address; equals current PC.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  returned instruction word.
- `redirect_valid`  in  1  downstream requests a PC change (taken branch).
- `redirect_target`  in  32  new PC; bits [1:0] ignored, forced to 00.
- `out_valid`  out  1  decoded instruction fields are valid.
- `out_ready`  in  1  consumer accepts the current instruction.
- `instr_op`  out  6  instr[31:26], to `controlUnit.instr_op`.
- `instr_field`  out  6  instr[5:0], to `aluControlUnit.instruction_5_0`.
- `rs`, `rt`, `rd`  out  5 each  instr[25:21], [20:16], [15:11].
- `imm_sext`  out  32  instr[15:0] sign-extended.
- `pc_out`  out  32  address of the presented instruction.
- `pc_plus4`  out  32  `pc_out` + 4, modulo 2^32.
- `instr_count`  out  32  number of accepted instructions, wraps at 2^32.

## Operation
- States: RESET, FETCH, WAIT, HOLD.
- Reset (async, `rst_n`=0): state RESET, PC=`RESET_PC`, discard flag=0, `imem_req`=0, `out_valid`=0, all field outputs 0, `pc_out`=0, `pc_plus4`=0, `instr_count`=0. `imem_addr` shows PC (= `RESET_PC`).
- RESET: unconditional -> FETCH on the first edge with `rst_n`=1.
- FETCH: `imem_req`=1 (Moore output, from state only), `imem_addr`=PC. `imem_gnt`=1 -> WAIT. Otherwise remain in FETCH, holding the request.
- WAIT: `imem_rvalid`=1 with discard=0 -> load output registers from `imem_rdata`, `pc_out`=PC, `pc_plus4`=PC+4, PC<=PC+4, `out_valid`<=1, go to HOLD. `imem_rvalid`=1 with discard=1 -> drop data, clear discard, go to FETCH.
- HOLD: `out_valid`=1. All field outputs and `pc_out` stay stable until the handshake completes. `out_valid`&&`out_ready` -> `out_valid`<=0, `instr_count`++, go to FETCH.
- Redirect has priority over every other event in every state except RESET (ignored there):
  - FETCH: PC<=target, stay in FETCH. If `imem_gnt` is also 1, go to WAIT with discard=1.
  - WAIT without `imem_rvalid`: PC<=target, discard<=1, stay in WAIT.
  - WAIT with `imem_rvalid`: drop data, PC<=target, discard<=0, go to FETCH.
  - HOLD: `out_valid`<=0, PC<=target, go to FETCH. A simultaneous `out_ready` still counts the instruction, because the handshake completed.
- Only one request is outstanding at a time. `imem_rvalid` outside WAIT is ignored.
- PC arithmetic is 32-bit unsigned with wrap: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Best case: FETCH (gnt) -> WAIT (rvalid) -> HOLD (ready) gives 3 cycles per instruction.
- Rising edge with gnt=1 in FETCH is cycle 0. The first rvalid can arrive in cycle 1. `out_valid` goes high after the edge that sampled rvalid.
- `out_valid` deasserts only via a completed handshake, a redirect, or reset.
- Reset asserted mid-fetch abandons the transaction. Any later `imem_rvalid` is ignored until the FSM reaches WAIT again.

## Test plan
- Reset release, memory grants immediately and returns 32'h0000_0020 (add) one cycle later, `out_ready`=1 -> `imem_addr`=0, `instr_op`=000000, `instr_field`=100000, `pc_out`=0, `pc_plus4`=4, `instr_count`=1, next `imem_addr`=4.
- `imem_rdata`=32'h8C22_FFFC (lw) -> `instr_op`=100011, `rs`=1, `rt`=2, `imm_sext`=32'hFFFF_FFFC.
- `out_ready` held low 5 cycles in HOLD -> `out_valid` and all fields stable for all 5 cycles, no new `imem_req`, count unchanged.
- Redirect to 32'h0000_0103 in WAIT, then rvalid with 32'h1234_5678 -> data dropped, `out_valid` stays 0, next `imem_addr`=32'h0000_0100.
- Redirect in HOLD together with `out_ready`=1 -> `instr_count` increments, `out_valid`=0, next fetch at the target address.
- `RESET_PC`=32'hFFFF_FFFC, one fetch -> `pc_plus4`=0, next `imem_addr`=0. Assert `rst_n`=0 during the next WAIT -> all outputs return to reset values immediately.
